// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and default vectors for the IF-stage program
//               counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Source selected for the next fetch PC, listed in priority order
    typedef enum logic [2:0] {
        PC_SRC_TRAP  = 3'd0,
        PC_SRC_HOLD  = 3'd1,
        PC_SRC_RET   = 3'd2,
        PC_SRC_CALL  = 3'd3,
        PC_SRC_REDIR = 3'd4,
        PC_SRC_SEQ   = 3'd5
    } pc_src_e;

    // Default vectors for the MUSA core
    localparam logic [31:0] MUSA_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] MUSA_TRAP_VECTOR  = 32'h0000_0080;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_return_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_return_stack
// Description : Circular return-address stack. A push on a full stack
//               silently overwrites the oldest entry; the count saturates.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             flush,
    input  logic [WIDTH-1:0]                 pushData,
    output logic [WIDTH-1:0]                 topData,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   count
);

    localparam int                 c_PTR_W = $clog2(RAS_DEPTH);
    localparam int                 c_CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(RAS_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0]   r_stack [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_top;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] w_top_inc;
    logic [c_PTR_W-1:0] w_top_dec;

    // Modular neighbours of the top pointer (depth need not be a power of two)
    always_comb begin
        w_top_inc = (r_top == c_LAST) ? '0 : r_top + 1'b1;
        w_top_dec = (r_top == '0) ? c_LAST : r_top - 1'b1;
    end

    // Top pointer and saturating occupancy counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_top <= w_top_inc;
            if (r_count != c_FULL) begin
                r_count <= r_count + 1'b1;
            end
        end else if (pop && (r_count != '0)) begin
            r_top   <= w_top_dec;
            r_count <= r_count - 1'b1;
        end
    end

    // Entry storage; contents are meaningless while count is zero, so no reset
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            r_stack[w_top_inc] <= pushData;
        end
    end

    assign topData = r_stack[r_top];
    assign count   = r_count;

endmodule : pc_return_stack
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : IF-stage program counter. Picks the next PC from trap
//               vector, return-address stack, call/branch target or the
//               sequential increment, honouring a stall enable.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = MUSA_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = MUSA_TRAP_VECTOR,
    parameter int          INCREMENT    = 4,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             pcWrite,
    input  logic                             trapValid,
    input  logic                             redirectValid,
    input  logic                             callValid,
    input  logic                             returnValid,
    input  logic [WIDTH-1:0]                 redirectTarget,
    output logic [WIDTH-1:0]                 pcOutput,
    output logic [WIDTH-1:0]                 pcPlus,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   rasCount,
    output logic                             rasEmpty,
    output logic                             rasFull,
    output logic                             rasError,
    output logic                             misalignError
);

    localparam int             c_CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] c_RESET_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] c_TRAP_PC  = WIDTH'(TRAP_VECTOR);
    localparam logic [WIDTH-1:0] c_STEP     = WIDTH'(INCREMENT);
    // Low bits that must be zero in a target; all-zero when INCREMENT is 1
    localparam logic [WIDTH-1:0] c_LOW_MASK = WIDTH'(INCREMENT - 1);

    logic [WIDTH-1:0]   r_pc;
    logic               r_ras_error;
    logic               r_misalign;

    pc_src_e            w_src;
    logic [WIDTH-1:0]   w_pc_plus;
    logic [WIDTH-1:0]   w_aligned;
    logic               w_target_odd;
    logic [WIDTH-1:0]   w_next_pc;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_ras_error;
    logic               w_misalign;
    logic [WIDTH-1:0]   w_top;
    logic [c_CNT_W-1:0] w_count;
    logic               w_empty;

    assign w_pc_plus    = r_pc + c_STEP;
    assign w_aligned    = redirectTarget & ~c_LOW_MASK;
    assign w_target_odd = |(redirectTarget & c_LOW_MASK);
    assign w_empty      = (w_count == '0);

    // Fixed-priority choice of the next-PC source
    always_comb begin
        w_src = PC_SRC_SEQ;
        if (trapValid) begin
            w_src = PC_SRC_TRAP;
        end else if (!pcWrite) begin
            w_src = PC_SRC_HOLD;
        end else if (returnValid) begin
            w_src = PC_SRC_RET;
        end else if (callValid) begin
            w_src = PC_SRC_CALL;
        end else if (redirectValid) begin
            w_src = PC_SRC_REDIR;
        end
    end

    // Next PC, stack controls and error pulses for the chosen source
    always_comb begin
        w_next_pc   = w_pc_plus;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_ras_error = 1'b0;
        w_misalign  = 1'b0;
        case (w_src)
            PC_SRC_TRAP: begin
                w_next_pc = c_TRAP_PC;
                w_flush   = 1'b1;
            end
            PC_SRC_HOLD: begin
                w_next_pc = r_pc;
            end
            PC_SRC_RET: begin
                // A simultaneous call is dropped and flagged as a stack error
                if (w_empty) begin
                    w_next_pc   = w_pc_plus;
                    w_ras_error = 1'b1;
                end else begin
                    w_next_pc = w_top;
                    w_pop     = 1'b1;
                end
                if (callValid) begin
                    w_ras_error = 1'b1;
                end
            end
            PC_SRC_CALL: begin
                w_next_pc  = w_aligned;
                w_push     = 1'b1;
                w_misalign = w_target_odd;
            end
            PC_SRC_REDIR: begin
                w_next_pc  = w_aligned;
                w_misalign = w_target_odd;
            end
            default: begin
                w_next_pc = w_pc_plus;
            end
        endcase
    end

    // PC register and one-cycle error pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc        <= c_RESET_PC;
            r_ras_error <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_pc        <= w_next_pc;
            r_ras_error <= w_ras_error;
            r_misalign  <= w_misalign;
        end
    end

    pc_return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock    (clock),
        .reset    (reset),
        .push     (w_push),
        .pop      (w_pop),
        .flush    (w_flush),
        .pushData (w_pc_plus),
        .topData  (w_top),
        .count    (w_count)
    );

    assign pcOutput      = r_pc;
    assign pcPlus        = w_pc_plus;
    assign rasCount      = w_count;
    assign rasEmpty      = w_empty;
    assign rasFull       = (w_count == c_CNT_W'(RAS_DEPTH));
    assign rasError      = r_ras_error;
    assign misalignError = r_misalign;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer: directed scenarios and
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clock;
    logic        reset;
    logic        pcWrite, trapValid, redirectValid, callValid, returnValid;
    logic [31:0] redirectTarget;
    logic [31:0] pcOutput, pcPlus;
    logic [2:0]  rasCount;
    logic        rasEmpty, rasFull, rasError, misalignError;

    // Narrow instance used only for the wrap-around case
    logic        reset8, pcWrite8, redir8, zero8;
    logic [7:0]  tgt8, pc8, pcp8;
    logic [2:0]  cnt8;
    logic        empty8, full8, rerr8, merr8;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] ras_q [$];
    logic        m_rerr, m_merr;

    pc_sequencer #(
        .WIDTH(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h80),
        .INCREMENT(4), .RAS_DEPTH(4)
    ) dut (
        .clock(clock), .reset(reset), .pcWrite(pcWrite), .trapValid(trapValid),
        .redirectValid(redirectValid), .callValid(callValid), .returnValid(returnValid),
        .redirectTarget(redirectTarget), .pcOutput(pcOutput), .pcPlus(pcPlus),
        .rasCount(rasCount), .rasEmpty(rasEmpty), .rasFull(rasFull),
        .rasError(rasError), .misalignError(misalignError)
    );

    pc_sequencer #(
        .WIDTH(8), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h80),
        .INCREMENT(4), .RAS_DEPTH(4)
    ) dut8 (
        .clock(clock), .reset(reset8), .pcWrite(pcWrite8), .trapValid(zero8),
        .redirectValid(redir8), .callValid(zero8), .returnValid(zero8),
        .redirectTarget(tgt8), .pcOutput(pc8), .pcPlus(pcp8),
        .rasCount(cnt8), .rasEmpty(empty8), .rasFull(full8),
        .rasError(rerr8), .misalignError(merr8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance the reference model by one edge using the currently driven inputs
    task automatic model_step();
        m_rerr = 1'b0;
        m_merr = 1'b0;
        if (!reset) begin
            m_pc = 32'h0;
            ras_q.delete();
        end else if (trapValid) begin
            m_pc = 32'h80;
            ras_q.delete();
        end else if (!pcWrite) begin
            // stalled: nothing changes
        end else if (returnValid) begin
            if (ras_q.size() > 0) m_pc = ras_q.pop_back();
            else begin
                m_pc   = m_pc + 32'd4;
                m_rerr = 1'b1;
            end
            if (callValid) m_rerr = 1'b1;
        end else if (callValid) begin
            if (ras_q.size() == 4) void'(ras_q.pop_front());
            ras_q.push_back(m_pc + 32'd4);
            m_merr = (redirectTarget % 4) != 0;
            m_pc   = redirectTarget - (redirectTarget % 4);
        end else if (redirectValid) begin
            m_merr = (redirectTarget % 4) != 0;
            m_pc   = redirectTarget - (redirectTarget % 4);
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        trapValid = 0; redirectValid = 0; callValid = 0; returnValid = 0;
        redirectTarget = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        pcWrite = 1'b1;
        reset   = 1'b1;
        #2 reset = 1'b0;
        m_pc = 32'h0; ras_q.delete(); m_rerr = 0; m_merr = 0;
        #1;
        tests_run++;
        if (pcOutput !== 32'h0 || rasCount !== 3'd0 || rasEmpty !== 1'b1 ||
            rasError !== 1'b0 || misalignError !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: pc=%h cnt=%0d empty=%b rerr=%b merr=%b required pc=0 cnt=0 empty=1 errs=0",
                     pcOutput, rasCount, rasEmpty, rasError, misalignError);
        end
        tick();
        tests_run++;
        if (pcOutput !== 32'h0 || rasCount !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_held: pc=%h cnt=%0d required pc=0 cnt=0", pcOutput, rasCount);
        end
    endtask

    task automatic test_free_run();
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests_run++;
            if (pcOutput !== 32'(i * 4) || rasEmpty !== 1'b1 || pcPlus !== 32'(i * 4 + 4)) begin
                tests_failed++;
                $display("FAIL free_run[%0d]: pc=%h pcPlus=%h empty=%b required pc=%h pcPlus=%h empty=1",
                         i, pcOutput, pcPlus, rasEmpty, i * 4, i * 4 + 4);
            end
        end
    endtask

    task automatic test_stall_trap();
        pcWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (pcOutput !== 32'd16) begin
                tests_failed++;
                $display("FAIL stall[%0d]: pc=%h required 10", i, pcOutput);
            end
        end
        trapValid = 1'b1;
        tick();
        trapValid = 1'b0;
        tests_run++;
        if (pcOutput !== 32'h80 || rasCount !== 3'd0) begin
            tests_failed++;
            $display("FAIL trap_in_stall: pc=%h cnt=%0d required pc=80 cnt=0", pcOutput, rasCount);
        end
        pcWrite = 1'b1;
    endtask

    task automatic test_call_return();
        redirectValid = 1'b1; redirectTarget = 32'h100;
        tick();
        redirectValid = 1'b0;
        callValid = 1'b1; redirectTarget = 32'h200;
        tick();
        callValid = 1'b0;
        tests_run++;
        if (pcOutput !== 32'h200 || rasCount !== 3'd1) begin
            tests_failed++;
            $display("FAIL call: pc=%h cnt=%0d required pc=200 cnt=1", pcOutput, rasCount);
        end
        returnValid = 1'b1;
        tick();
        returnValid = 1'b0;
        tests_run++;
        if (pcOutput !== 32'h104 || rasCount !== 3'd0 || rasError !== 1'b0) begin
            tests_failed++;
            $display("FAIL return: pc=%h cnt=%0d rerr=%b required pc=104 cnt=0 rerr=0",
                     pcOutput, rasCount, rasError);
        end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] ret_addr [5];
        logic [31:0] cur;
        cur = 32'h104;
        for (int i = 0; i < 5; i++) begin
            ret_addr[i]    = cur + 32'd4;
            cur            = 32'(i + 1) << 12;
            callValid      = 1'b1;
            redirectTarget = cur;
            tick();
        end
        callValid = 1'b0;
        tests_run++;
        if (pcOutput !== cur || rasCount !== 3'd4 || rasFull !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_push: pc=%h cnt=%0d full=%b required pc=%h cnt=4 full=1",
                     pcOutput, rasCount, rasFull, cur);
        end
        returnValid = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            tick();
            tests_run++;
            if (pcOutput !== ret_addr[i] || rasError !== 1'b0) begin
                tests_failed++;
                $display("FAIL overflow_pop[%0d]: pc=%h rerr=%b required pc=%h rerr=0",
                         i, pcOutput, rasError, ret_addr[i]);
            end
        end
        tick();
        returnValid = 1'b0;
        tests_run++;
        if (pcOutput !== ret_addr[1] + 32'd4 || rasError !== 1'b1 || rasEmpty !== 1'b1) begin
            tests_failed++;
            $display("FAIL return_empty: pc=%h rerr=%b empty=%b required pc=%h rerr=1 empty=1",
                     pcOutput, rasError, rasEmpty, ret_addr[1] + 32'd4);
        end
        tick();
        tests_run++;
        if (rasError !== 1'b0 || pcOutput !== ret_addr[1] + 32'd8) begin
            tests_failed++;
            $display("FAIL rerr_pulse: rerr=%b pc=%h required rerr=0 pc=%h",
                     rasError, pcOutput, ret_addr[1] + 32'd8);
        end
    endtask

    task automatic test_misalign();
        redirectValid = 1'b1; redirectTarget = 32'h203;
        tick();
        redirectValid = 1'b0;
        tests_run++;
        if (pcOutput !== 32'h200 || misalignError !== 1'b1) begin
            tests_failed++;
            $display("FAIL misalign: pc=%h merr=%b required pc=200 merr=1", pcOutput, misalignError);
        end
        tick();
        tests_run++;
        if (pcOutput !== 32'h204 || misalignError !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_pulse: pc=%h merr=%b required pc=204 merr=0", pcOutput, misalignError);
        end
    endtask

    task automatic test_conflict();
        callValid = 1'b1; redirectTarget = 32'h300;
        tick();
        returnValid = 1'b1; redirectTarget = 32'h400;
        tick();
        callValid = 1'b0; returnValid = 1'b0;
        tests_run++;
        if (pcOutput !== 32'h208 || rasCount !== 3'd0 || rasError !== 1'b1) begin
            tests_failed++;
            $display("FAIL call_return_conflict: pc=%h cnt=%0d rerr=%b required pc=208 cnt=0 rerr=1",
                     pcOutput, rasCount, rasError);
        end
    endtask

    task automatic test_async_reset();
        callValid = 1'b1; redirectTarget = 32'h40;
        tick();
        redirectTarget = 32'h500;
        #3 reset = 1'b0;
        #1;
        tests_run++;
        if (pcOutput !== 32'h0 || rasCount !== 3'd0 || rasEmpty !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_call: pc=%h cnt=%0d empty=%b required pc=0 cnt=0 empty=1",
                     pcOutput, rasCount, rasEmpty);
        end
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
        tests_run++;
        if (pcOutput !== 32'h4 || rasCount !== 3'd0) begin
            tests_failed++;
            $display("FAIL after_reset: pc=%h cnt=%0d required pc=4 cnt=0", pcOutput, rasCount);
        end
    endtask

    task automatic test_random();
        int bad;
        for (int n = 0; n < 400; n++) begin
            trapValid      = ($urandom_range(0, 19) == 0);
            pcWrite        = ($urandom_range(0, 4) != 0);
            returnValid    = ($urandom_range(0, 4) == 0);
            callValid      = ($urandom_range(0, 3) == 0);
            redirectValid  = ($urandom_range(0, 3) == 0);
            redirectTarget = $urandom();
            if ($urandom_range(0, 2) != 0) redirectTarget[1:0] = 2'b00;
            tick();
            bad = 0;
            if (pcOutput !== m_pc || pcPlus !== m_pc + 32'd4) bad = 1;
            if (rasCount !== 3'(ras_q.size())) bad = 1;
            if (rasEmpty !== (ras_q.size() == 0) || rasFull !== (ras_q.size() == 4)) bad = 1;
            if (rasError !== m_rerr || misalignError !== m_merr) bad = 1;
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL random[%0d]: pc=%h cnt=%0d rerr=%b merr=%b required pc=%h cnt=%0d rerr=%b merr=%b",
                         n, pcOutput, rasCount, rasError, misalignError,
                         m_pc, ras_q.size(), m_rerr, m_merr);
            end
        end
        clear_inputs();
        pcWrite = 1'b1;
    endtask

    task automatic test_wrap();
        reset8 = 1'b0;
        #1;
        tests_run++;
        if (pc8 !== 8'h00) begin
            tests_failed++;
            $display("FAIL wrap_reset: pc=%h required 00", pc8);
        end
        reset8 = 1'b1; pcWrite8 = 1'b1; redir8 = 1'b1; tgt8 = 8'hFC;
        tick();
        redir8 = 1'b0;
        tests_run++;
        if (pc8 !== 8'hFC || pcp8 !== 8'h00) begin
            tests_failed++;
            $display("FAIL wrap_pcplus: pc=%h pcPlus=%h required pc=FC pcPlus=00", pc8, pcp8);
        end
        tick();
        tests_run++;
        if (pc8 !== 8'h00 || merr8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_pc: pc=%h merr=%b required pc=00 merr=0", pc8, merr8);
        end
    endtask

    initial begin
        reset8 = 1'b0; pcWrite8 = 1'b0; redir8 = 1'b0; zero8 = 1'b0; tgt8 = 8'h00;
        test_reset();
        test_free_run();
        test_stall_trap();
        test_call_return();
        test_ras_overflow();
        test_misalign();
        test_conflict();
        test_async_reset();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
